// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and widths for the instruction-memory boot loader
package imem_loader_pkg;
  localparam int BYTE_W    = 8;
  localparam int WORD_W    = 32;
  localparam int LEN_BYTES = 2;
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CHECK, DONE, ERROR} state_e;
  function automatic logic rx_state(input state_e s);
    return s inside {LEN0, LEN1, DATA, CHECK};
  endfunction
endpackage

// File: rtl/byte_word_packer.sv
// byte_word_packer: assembles little-endian bytes into words, flags the byte that completes a word
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic [WORD_W-1:0] word_o,
  output logic              full_o
);
  logic [1:0]        cnt_q;
  logic [WORD_W-1:0] word_q;
  // word_o already includes data_i so the completed word is usable in the cycle full_o fires
  assign word_o = {data_i, word_q[WORD_W-1:BYTE_W]};
  assign full_o = push_i && cnt_q == 2'd3;
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (push_i) begin
      cnt_q  <= cnt_q + 2'd1;
      word_q <= word_o;
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a framed, checksummed byte stream into instruction memory
// and holds the core in reset until a complete, verified image is present.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 256,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_start_i,
  input  logic [BYTE_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  output logic              imem_we_o,
  output logic [WORD_W-1:0] imem_addr_o,
  output logic [WORD_W-1:0] imem_wdata_o,
  output logic              core_rst_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);
  state_e                        state_q, state_d;
  logic [LEN_BYTES*BYTE_W-1:0]   len_q, len_full;
  logic [15:0]                   k_q;
  logic [BYTE_W-1:0]             sum_q;
  logic [31:0]                   tmo_q;
  logic                          rx_ready_q, imem_we_q, core_rst_n_q, busy_q, done_q, error_q;
  logic [WORD_W-1:0]             imem_addr_q, imem_wdata_q, word;
  logic                          fire, start, full, len_bad, tmo_hit;

  assign fire     = rx_valid_i && rx_ready_q;
  assign start    = load_start_i && state_q inside {IDLE, DONE, ERROR};
  assign len_full = {rx_data_i, len_q[BYTE_W-1:0]};
  assign len_bad  = len_full == '0 || {16'b0, len_full} > MAX_WORDS;
  assign tmo_hit  = rx_state(state_q) && !fire && tmo_q == TIMEOUT_CYCLES - 1;

  byte_word_packer u_packer (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr_i (start),
    .push_i(fire && state_q == DATA),
    .data_i(rx_data_i),
    .word_o(word),
    .full_o(full)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERROR: state_d = start ? LEN0 : state_q;
      LEN0:              state_d = fire ? LEN1 : LEN0;
      LEN1:              state_d = fire ? (len_bad ? ERROR : DATA) : LEN1;
      DATA:              state_d = full ? WRITE : DATA;
      WRITE:             state_d = (k_q + 16'd1 == len_q) ? CHECK : DATA;
      CHECK:             state_d = fire ? (rx_data_i == sum_q ? DONE : ERROR) : CHECK;
      default:           state_d = IDLE;
    endcase
    if (tmo_hit) state_d = ERROR;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      len_q        <= '0;
      k_q          <= '0;
      sum_q        <= '0;
      tmo_q        <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= BASE_ADDR;
      imem_wdata_q <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_ready_q   <= rx_state(state_d);
      busy_q       <= rx_state(state_d) || state_d == WRITE;
      done_q       <= state_d == DONE;
      error_q      <= state_d == ERROR;
      // core only leaves reset once the idle/done state has been held for a full cycle
      core_rst_n_q <= state_d inside {IDLE, DONE} && state_q inside {IDLE, DONE};
      imem_we_q    <= state_d == WRITE;
      if (state_d == WRITE) begin
        imem_addr_q  <= BASE_ADDR + {14'b0, k_q, 2'b00};
        imem_wdata_q <= word;
      end
      if (state_q == LEN0 && fire) len_q[BYTE_W-1:0] <= rx_data_i;
      if (state_q == LEN1 && fire) len_q <= len_full;
      k_q   <= start ? '0 : k_q + 16'(state_q == WRITE);
      sum_q <= start ? '0 : (state_q == DATA && fire) ? sum_q + rx_data_i : sum_q;
      tmo_q <= (start || fire) ? '0 : rx_state(state_q) ? tmo_q + 32'd1 : tmo_q;
    end
  end

  assign rx_ready_o   = rx_ready_q;
  assign imem_we_o    = imem_we_q;
  assign imem_addr_o  = imem_addr_q;
  assign imem_wdata_o = imem_wdata_q;
  assign core_rst_n_o = core_rst_n_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign error_o      = error_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed boot-loader bench; memory writes are checked against a scoreboard queue
module tb_imem_boot_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  logic        clk = 1'b0, rst_n = 1'b0, load_start = 1'b0, rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready, imem_we, core_rst_n, busy, done, error;
  logic [31:0] imem_addr, imem_wdata;
  int          cmp = 0, mism = 0, writes = 0, cyc = 0;
  logic [63:0] exp_q[$];
  logic [31:0] img [4];

  imem_boot_loader #(.BASE_ADDR(BASE), .MAX_WORDS(256), .TIMEOUT_CYCLES(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .load_start_i(load_start),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready),
    .imem_we_o   (imem_we),
    .imem_addr_o (imem_addr),
    .imem_wdata_o(imem_wdata),
    .core_rst_n_o(core_rst_n),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    cmp++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (imem_we === 1'b1) begin
      writes++;
      chk1("write_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("imem_addr", imem_addr, e[63:32]);
        chk("imem_wdata", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit rnd);
    int n = 0;
    if (rnd && $urandom_range(0, 1) == 1) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk1("rx_ready_within_bound", n < 50, 1'b1);
    @(negedge clk);
  endtask

  task automatic frame(input int n, input logic [7:0] bad, input bit rnd);
    logic [7:0]  s = 8'h00;
    logic [15:0] len = 16'(n);
    logic [31:0] w;
    send(len[7:0], rnd);
    send(len[15:8], rnd);
    for (int i = 0; i < n; i++) begin
      w = img[i];
      exp_q.push_back({BASE + 32'(i) * 32'd4, w});
      for (int j = 0; j < 4; j++) begin
        s = s + w[8*j +: 8];
        send(w[8*j +: 8], rnd);
      end
    end
    send(s ^ bad, rnd);
    rx_valid = 1'b0;
  endtask

  task automatic start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  initial begin
    int t0, n, w0;
    logic [31:0] w;
    repeat (2) @(negedge clk);
    chk1("rst_rx_ready", rx_ready, 1'b0);
    chk1("rst_imem_we", imem_we, 1'b0);
    chk("rst_imem_addr", imem_addr, BASE);
    chk("rst_imem_wdata", imem_wdata, 32'h0);
    chk1("rst_core_rst_n", core_rst_n, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_error", error, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("idle_core_rst_n", core_rst_n, 1'b1);
    chk1("idle_rx_ready", rx_ready, 1'b0);
    chk("idle_no_writes", 32'(writes), 32'd0);

    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    start();
    chk1("load_busy", busy, 1'b1);
    chk1("load_core_rst_n", core_rst_n, 1'b0);
    chk1("load_rx_ready", rx_ready, 1'b1);
    t0 = cyc;
    frame(2, 8'h00, 1'b0);
    chk("good_cycles", 32'(cyc - t0), 32'd13);
    chk1("good_done", done, 1'b1);
    chk1("good_error", error, 1'b0);
    chk1("good_busy", busy, 1'b0);
    chk1("good_core_held_first_cycle", core_rst_n, 1'b0);
    chk("good_all_written", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk1("good_core_released", core_rst_n, 1'b1);

    start();
    chk1("restart_done_cleared", done, 1'b0);
    frame(2, 8'h03, 1'b0);
    chk1("badsum_error", error, 1'b1);
    chk1("badsum_done", done, 1'b0);
    chk1("badsum_core_rst_n", core_rst_n, 1'b0);
    chk("badsum_all_written", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk1("badsum_core_still_held", core_rst_n, 1'b0);

    w0 = writes;
    start();
    chk1("restart_error_cleared", error, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    rx_valid = 1'b0;
    chk1("len0_error", error, 1'b1);
    chk1("len0_rx_ready", rx_ready, 1'b0);
    chk1("len0_busy", busy, 1'b0);
    start();
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    rx_valid = 1'b0;
    chk1("len257_error", error, 1'b1);
    chk("badlen_no_writes", 32'(writes - w0), 32'd0);

    img[0] = 32'hDEAD_BEEF;
    start();
    send(8'h01, 1'b0);
    send(8'h00, 1'b0);
    send(8'hEF, 1'b0);
    send(8'hBE, 1'b0);
    rx_valid = 1'b0;
    n = 0;
    while (error !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'd16);
    chk1("timeout_error", error, 1'b1);
    start();
    frame(1, 8'h00, 1'b0);
    chk1("after_timeout_done", done, 1'b1);
    chk1("after_timeout_error", error, 1'b0);
    chk("after_timeout_written", 32'(exp_q.size()), 32'd0);

    img[0] = 32'hA5C3_0001;
    img[1] = 32'h1234_5678;
    w0 = writes;
    start();
    send(8'h03, 1'b1);
    send(8'h00, 1'b1);
    exp_q.push_back({BASE, img[0]});
    w = img[0];
    for (int j = 0; j < 4; j++) send(w[8*j +: 8], 1'b1);
    w = img[1];
    for (int j = 0; j < 2; j++) send(w[8*j +: 8], 1'b1);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    chk1("midrst_rx_ready", rx_ready, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk1("midrst_error", error, 1'b0);
    chk1("midrst_imem_we", imem_we, 1'b0);
    chk1("midrst_core_rst_n", core_rst_n, 1'b0);
    chk("midrst_writes", 32'(writes - w0), 32'd1);
    chk("midrst_queue", 32'(exp_q.size()), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("postrst_core_rst_n", core_rst_n, 1'b1);
    chk1("postrst_rx_ready", rx_ready, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule
